// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of the 16-bit combinational execute ALU.
// Reads operands from a small register file, registers a/b/config_ for the
// ALU, and commits the returned c back to the register file. Every commit is
// also shown on a trace port with backpressure.
// Optional feature macro: ALU_FWD_EN
//   defined   - the committing result is bypassed into the operand read, so
//               there is no hazard stall
//   undefined - no bypass; a RAW hazard on the stage register stalls issue
//               for one bubble
module alu_issue_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 4,
  parameter int unsigned RAW   = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  // Instruction intake
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [RAW-1:0]   in_rd,
  input  logic [RAW-1:0]   in_rs1,
  input  logic [RAW-1:0]   in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  // ALU interface
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [1:0]       config_,
  input  logic [WIDTH-1:0] c,
  // Commit trace
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RAW-1:0]   out_rd,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpMul = 2'd2,
    OpLdi = 2'd3
  } op_e;

  // Parameter sanity: the register index must address every register exactly.
  if (RAW != $clog2(NREGS)) begin : g_bad_raw
    $error("RAW must equal clog2(NREGS)");
  end
  if (NREGS != (1 << RAW)) begin : g_bad_nregs
    $error("NREGS must be a power of two");
  end

  // Architectural register file
  logic [WIDTH-1:0] rf_q [NREGS];

  // One-entry stage register feeding the ALU
  logic             s_valid_q, s_valid_d;
  op_e              s_op_q,    s_op_d;
  logic [RAW-1:0]   s_rd_q,    s_rd_d;
  logic [WIDTH-1:0] s_a_q,     s_a_d;
  logic [WIDTH-1:0] s_b_q,     s_b_d;

  logic             commit;
  logic             accept;
  logic             hazard;
  logic             in_is_ldi;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;

  assign in_is_ldi = (op_e'(in_op) == OpLdi);

  // ALU and trace outputs come straight from the stage register, so they are
  // stable for as long as the stage is stalled.
  assign a         = s_a_q;
  assign b         = s_b_q;
  assign config_   = s_op_q;
  assign out_valid = s_valid_q;
  assign out_rd    = s_rd_q;

  // LDI bypasses the ALU: the immediate already sits in s_a.
  assign out_data = (s_op_q == OpLdi) ? s_a_q : c;

  assign commit = s_valid_q && out_ready;

`ifdef ALU_FWD_EN
  assign hazard = 1'b0;
`else
  // Without a bypass, a source matching the in-flight destination must wait
  // until that result has reached the register file.
  assign hazard = s_valid_q && !in_is_ldi && ((s_rd_q == in_rs1) || (s_rd_q == in_rs2));
`endif

  assign in_ready = (!s_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Operand read, with the committing result bypassed when enabled
  always_comb begin
    rs1_val = rf_q[in_rs1];
    rs2_val = rf_q[in_rs2];
`ifdef ALU_FWD_EN
    if (commit && (s_rd_q == in_rs1)) begin
      rs1_val = out_data;
    end
    if (commit && (s_rd_q == in_rs2)) begin
      rs2_val = out_data;
    end
`endif
  end

  // Stage next-state: load on accept, empty on a bare commit, hold otherwise
  always_comb begin
    s_valid_d = s_valid_q;
    s_op_d    = s_op_q;
    s_rd_d    = s_rd_q;
    s_a_d     = s_a_q;
    s_b_d     = s_b_q;
    if (accept) begin
      s_valid_d = 1'b1;
      s_op_d    = op_e'(in_op);
      s_rd_d    = in_rd;
      if (in_is_ldi) begin
        s_a_d = in_imm;
        s_b_d = '0;
      end else begin
        s_a_d = rs1_val;
        s_b_d = rs2_val;
      end
    end else if (commit) begin
      s_valid_d = 1'b0;
    end
  end

  // Stage register; reset discards any in-flight instruction
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s_valid_q <= 1'b0;
      s_op_q    <= OpAdd;
      s_rd_q    <= '0;
      s_a_q     <= '0;
      s_b_q     <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_op_q    <= s_op_d;
      s_rd_q    <= s_rd_d;
      s_a_q     <= s_a_d;
      s_b_q     <= s_b_d;
    end
  end

  // Register file writeback on commit; reset wins so an in-flight result is lost
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (commit) begin
      rf_q[s_rd_q] <= out_data;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboarded bench for alu_issue_stage with a behavioural 16-bit ALU.
module tb_alu_issue_stage;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned RAW   = 2;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_LDI = 2'd3;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [RAW-1:0]   in_rd, in_rs1, in_rs2;
  logic [WIDTH-1:0] in_imm;
  logic [WIDTH-1:0] a, b, c;
  logic [1:0]       config_;
  logic             out_valid;
  logic             out_ready;
  logic [RAW-1:0]   out_rd;
  logic [WIDTH-1:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [RAW+WIDTH-1:0] sb [$];

  alu_issue_stage #(.WIDTH(WIDTH), .NREGS(4), .RAW(RAW)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .a(a), .b(b), .config_(config_), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data)
  );

  always #5 CLK = ~CLK;

  // Execute ALU; config 3 returns junk the stage must ignore
  always_comb begin
    c = 16'hDEAD;
    case (config_)
      2'd0:    c = a + b;
      2'd1:    c = a - b;
      2'd2:    c = a * b;
      default: c = 16'hDEAD;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: every trace handshake pops one expected commit
  always @(negedge CLK) begin
    if (RESET === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got rd=%0d data=%h want=nothing", out_rd, out_data);
      end else begin
        logic [RAW+WIDTH-1:0] e;
        e = sb.pop_front();
        if ({out_rd, out_data} !== e) begin
          errors++;
          $display("FAIL sb_commit got rd=%0d data=%h want rd=%0d data=%h",
                   out_rd, out_data, e[RAW+WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  // Offer one instruction; returns at accept edge + 1, with stall cycles counted
  task automatic issue(input logic [1:0] op, input logic [RAW-1:0] rd, input logic [RAW-1:0] rs1,
                       input logic [RAW-1:0] rs2, input logic [WIDTH-1:0] imm,
                       input logic [WIDTH-1:0] exp, input bit push, output int waits);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    waits    = 0;
    @(negedge CLK);
    while (in_ready !== 1'b1 && waits < 50) begin
      waits++;
      @(negedge CLK);
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout got in_ready=%b want 1 within 50 cycles", in_ready);
    end else if (push) begin
      sb.push_back({rd, exp});
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    RESET     = 1'b1;
    in_valid  = 1'b1;
    in_op     = OP_LDI;
    in_rd     = 2'd1;
    in_rs1    = 2'd0;
    in_rs2    = 2'd0;
    in_imm    = 16'hFFFF;
    out_ready = 1'b1;

    // Reset held two edges with an instruction offered
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ab", {a, b}, 32'd0);
      chk("rst_config", 32'(config_), 32'd0);
    end
    RESET    = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_a", 32'(a), 32'd0);
    @(posedge CLK);
    #1;

    // Readback of every register: rk + rk must be zero
    for (int k = 0; k < 4; k++) begin
      issue(OP_ADD, 2'(k), 2'(k), 2'(k), 16'h0, 16'h0000, 1'b1, w);
      chk("readback_ab", {a, b}, 32'd0);
    end
    repeat (3) @(posedge CLK);
    #1;

    // Back-to-back LDI, LDI, dependent ADD
    issue(OP_LDI, 2'd1, 2'd3, 2'd3, 16'd5, 16'd5, 1'b1, w);
    chk("ldi1_wait", 32'(w), 32'd0);
    chk("ldi1_ab", {a, b}, {16'd5, 16'd0});
    chk("ldi1_config", 32'(config_), 32'(OP_LDI));
    issue(OP_LDI, 2'd2, 2'd1, 2'd1, 16'd3, 16'd3, 1'b1, w);
    chk("ldi2_wait", 32'(w), 32'd0);
    issue(OP_ADD, 2'd3, 2'd1, 2'd2, 16'h0, 16'd8, 1'b1, w);
`ifdef ALU_FWD_EN
    chk("add_bubbles", 32'(w), 32'd0);
`else
    chk("add_bubbles", 32'(w), 32'd1);
`endif
    chk("add_ab", {a, b}, {16'd5, 16'd3});
    chk("add_config", 32'(config_), 32'(OP_ADD));

    // Wrap and multiply truncation
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b1, w);
    issue(OP_LDI, 2'd2, 2'd0, 2'd0, 16'h0001, 16'h0001, 1'b1, w);
    issue(OP_SUB, 2'd3, 2'd1, 2'd2, 16'h0, 16'hFFFF, 1'b1, w);
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 16'h0100, 16'h0100, 1'b1, w);
    issue(OP_MUL, 2'd2, 2'd1, 2'd1, 16'h0, 16'h0000, 1'b1, w);
    repeat (3) @(posedge CLK);
    #1;

    // Backpressure: r1=0x0100, r3=0xFFFF
    out_ready = 1'b0;
    issue(OP_ADD, 2'd0, 2'd1, 2'd3, 16'h0, 16'h00FF, 1'b1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", {a, b}, {16'h0100, 16'hFFFF});
      chk("bp_hold_ctl", {28'd0, config_, out_rd}, {28'd0, OP_ADD, 2'd0});
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_after_in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK);
    #1;

    // Self-dependent chain with a toggling consumer
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 16'd1, 16'd1, 1'b1, w);
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          @(posedge CLK);
          #1;
          out_ready = ~out_ready;
        end
      end
      begin
        int ww;
        for (int i = 0; i < 4; i++) begin
          issue(OP_ADD, 2'd1, 2'd1, 2'd1, 16'h0, 16'(2 << i), 1'b1, ww);
        end
      end
    join
    out_ready = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    // Reset with LDI r0 in flight and the consumer ready
    issue(OP_LDI, 2'd0, 2'd0, 2'd0, 16'hAAAA, 16'hAAAA, 1'b0, w);
    chk("inflight_valid", 32'(out_valid), 32'd1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("inflight_dropped", 32'(out_valid), 32'd0);
    @(posedge CLK);
    #1;
    issue(OP_ADD, 2'd0, 2'd0, 2'd0, 16'h0, 16'h0000, 1'b1, w);
    chk("inflight_r0", {a, b}, 32'd0);

    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
